// File: rtl/pong_game_engine.sv
// pong_game_engine: Pong ball/paddle/score state per frame tick plus registered pixel colour; AI_PADDLE_EN makes the right paddle track the ball
module pong_game_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X_L   = 16,
    parameter int PADDLE_X_R   = 616,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_MAX    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       serve,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);
    localparam int CW = $clog2(SERVE_FRAMES);
    localparam logic [10:0] HR  = 11'(H_RES);
    localparam logic [10:0] VR  = 11'(V_RES);
    localparam logic [10:0] BS  = 11'(BALL_SIZE);
    localparam logic [10:0] PW  = 11'(PADDLE_W);
    localparam logic [10:0] PH  = 11'(PADDLE_H);
    localparam logic [10:0] XL  = 11'(PADDLE_X_L);
    localparam logic [10:0] XR  = 11'(PADDLE_X_R);
    localparam logic [10:0] BSP = 11'(BALL_SPEED);
    localparam logic [10:0] PSP = 11'(PADDLE_SPEED);
    localparam logic [9:0]  BX0  = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]  BY0  = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0]  PY0  = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0]  PMAX = 10'(V_RES - PADDLE_H);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [3:0]  SMAX = 4'(SCORE_MAX);

    typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} state_t;

    state_t st, st_n;
    logic [9:0] bx, by, pl, pr, bx_n, by_n, pl_n, pr_n;
    logic dxn, dyn, dxn_n, dyn_n;
    logic [3:0] sl, sr, sl_n, sr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [10:0] bx1, by1, pl1, pr1, xe, ye;
    logic up2, dn2, top, bot, hit_l, hit_r, miss_l, miss_r;
    logic in_ball, in_pad, net;
    logic [3:0] lvl;

    function automatic logic [9:0] pmove(input logic [9:0] p, input logic up, input logic dn);
        logic [10:0] q;
        q = {1'b0, p};
        return (up & ~dn) ? ((q < PSP) ? 10'd0 : 10'(q - PSP)) :
               (dn & ~up) ? ((q + PSP > {1'b0, PMAX}) ? PMAX : 10'(q + PSP)) : p;
    endfunction

    assign bx1 = {1'b0, bx};
    assign by1 = {1'b0, by};
    assign pl1 = {1'b0, pl};
    assign pr1 = {1'b0, pr};
    assign xe  = {1'b0, x};
    assign ye  = {1'b0, y};

`ifdef AI_PADDLE_EN
    logic [10:0] tgt, pc;
    logic unused_p2;
    assign unused_p2 = p2_up ^ p2_down;
    assign tgt = by1 + BS / 2;
    assign pc  = pr1 + PH / 2;
    assign up2 = tgt + PSP < pc;
    assign dn2 = tgt > pc + PSP;
`else
    assign up2 = p2_up;
    assign dn2 = p2_down;
`endif

    assign top    = dyn && by1 < BSP;
    assign bot    = !dyn && by1 + BS + BSP > VR;
    assign hit_l  = dxn && bx1 <= XL + PW && bx1 + BS > XL && by1 + BS > pl1 && by1 < pl1 + PH;
    assign hit_r  = !dxn && bx1 + BS >= XR && bx1 < XR + PW && by1 + BS > pr1 && by1 < pr1 + PH;
    assign miss_l = dxn && bx1 < BSP;
    assign miss_r = !dxn && bx1 + BS + BSP > HR;

    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= SERVE;
            bx  <= BX0;
            by  <= BY0;
            dxn <= 1'b0;
            dyn <= 1'b0;
            pl  <= PY0;
            pr  <= PY0;
            sl  <= '0;
            sr  <= '0;
            cnt <= '0;
        end else begin
            st  <= st_n;
            bx  <= bx_n;
            by  <= by_n;
            dxn <= dxn_n;
            dyn <= dyn_n;
            pl  <= pl_n;
            pr  <= pr_n;
            sl  <= sl_n;
            sr  <= sr_n;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        st_n  = st;
        bx_n  = bx;
        by_n  = by;
        dxn_n = dxn;
        dyn_n = dyn;
        pl_n  = pl;
        pr_n  = pr;
        sl_n  = sl;
        sr_n  = sr;
        cnt_n = cnt;
        if (frame_tick) begin
            if (st != GAME_OVER) begin
                pl_n = pmove(pl, p1_up, p1_down);
                pr_n = pmove(pr, up2, dn2);
            end
            case (st)
                SERVE: begin
                    cnt_n = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                    st_n  = (cnt == CNT_LAST) ? PLAY : SERVE;
                end
                PLAY: begin
                    by_n  = top ? 10'd0 : bot ? 10'(VR - BS) : dyn ? 10'(by1 - BSP) : 10'(by1 + BSP);
                    dyn_n = top ? 1'b0 : bot ? 1'b1 : dyn;
                    if (hit_l) begin
                        bx_n  = 10'(XL + PW);
                        dxn_n = 1'b0;
                    end else if (hit_r) begin
                        bx_n  = 10'(XR - BS);
                        dxn_n = 1'b1;
                    end else if (miss_l) begin
                        sr_n = (sr < SMAX) ? sr + 4'd1 : sr;
                        st_n = POINT;
                    end else if (miss_r) begin
                        sl_n = (sl < SMAX) ? sl + 4'd1 : sl;
                        st_n = POINT;
                    end else begin
                        bx_n = dxn ? 10'(bx1 - BSP) : 10'(bx1 + BSP);
                    end
                end
                // dx still points at the player who conceded, so only re-centre here
                POINT: begin
                    bx_n = BX0;
                    by_n = BY0;
                    st_n = (sl == SMAX || sr == SMAX) ? GAME_OVER : SERVE;
                end
                default: begin
                    if (serve) begin
                        sl_n  = '0;
                        sr_n  = '0;
                        dxn_n = 1'b0;
                        st_n  = SERVE;
                    end
                end
            endcase
        end
    end

    assign in_ball = xe >= bx1 && xe < bx1 + BS && ye >= by1 && ye < by1 + BS;
    assign in_pad  = (xe >= XL && xe < XL + PW && ye >= pl1 && ye < pl1 + PH) ||
                     (xe >= XR && xe < XR + PW && ye >= pr1 && ye < pr1 + PH);
    assign net     = x == 10'(H_RES / 2) && !y[3];

    always_comb begin
        lvl       = !active ? 4'h0 : (in_ball || in_pad) ? 4'hF : net ? 4'h8 : 4'h0;
        game_over = st == GAME_OVER;
        score_l   = sl;
        score_r   = sr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= lvl;
            g <= lvl;
            b <= lvl;
        end
    end
endmodule
